// File: rtl/branch_resolution_unit.sv
// Branch resolution: checks fetch-time predictions against execute outcomes, updates the predictor, redirects fetch.
// Latency: update/redirect outputs are registered and appear one cycle after ex_valid is sampled.
// Backpressure: fifo_full tells fetch to stall branch fetch; pushes while full without a pop are dropped and flagged.
module branch_resolution_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 32,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_valid,
    input  logic [ADDRESS_BITS-1:0] fetch_pc,
    input  logic                    fetch_prediction,
    input  logic [ADDRESS_BITS-1:0] fetch_predicted_pc,
    output logic                    fifo_full,
    input  logic                    ex_valid,
    input  logic [6:0]              ex_opcode,
    input  logic [ADDRESS_BITS-1:0] ex_pc,
    input  logic                    ex_taken,
    input  logic [ADDRESS_BITS-1:0] ex_target,
    output logic                    actual_pred,
    output logic                    mispred,
    output logic [ADDRESS_BITS-1:0] update_pc,
    output logic [6:0]              update_opcode,
    output logic                    update_valid,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0]   branch_count,
    output logic [DATA_WIDTH-1:0]   mispred_count,
    output logic                    protocol_err
);

    localparam int PTR_W = $clog2(INFLIGHT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic                    pred;
        logic [ADDRESS_BITS-1:0] predicted_pc;
    } entry_t;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t             state;
    entry_t             mem [INFLIGHT_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic                    running;
    logic                    legal_op;
    logic                    resolve;
    logic                    bad_op;
    logic                    empty;
    logic                    full_now;
    logic [ADDRESS_BITS-1:0] pc_plus4;
    entry_t                  head;
    logic                    tag_err;
    logic                    mis;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    err_set;
    logic [CNT_W-1:0]        count_nxt;

    // Resolve decision: pick the FIFO head (or a not-taken default when empty) and classify the outcome.
    always_comb begin
        running  = (state == RUN);
        legal_op = (ex_opcode == OP_BRANCH) || (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
        resolve  = running & ex_valid & legal_op;
        bad_op   = running & ex_valid & ~legal_op;
        empty    = (count == '0);
        full_now = (count == CNT_W'(INFLIGHT_DEPTH));
        pc_plus4 = ex_pc + ADDRESS_BITS'(4);

        head = mem[rd_ptr];
        if (empty) begin
            head.pc           = ex_pc;
            head.pred         = 1'b0;
            head.predicted_pc = pc_plus4;
        end

        tag_err = resolve & ~empty & (head.pc != ex_pc);
        mis     = resolve & ((head.pred != ex_taken)
                           | (ex_taken & (head.predicted_pc != ex_target))
                           | (head.pc != ex_pc));
        pop     = resolve & ~empty;
        // A mispredict flushes the FIFO on this edge, so a same-cycle push is wrong-path and discarded.
        push    = running & fetch_valid & (~full_now | pop) & ~mis;
        drop    = running & fetch_valid & full_now & ~pop;
        err_set = bad_op | tag_err | (resolve & empty) | drop;

        if (mis) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage: written on accepted pushes only, no reset needed for the payload.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: fetch_pc, pred: fetch_prediction, predicted_pc: fetch_predicted_pc};
        end
    end

    // Control state, FIFO pointers, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            fifo_full      <= 1'b0;
            actual_pred    <= 1'b0;
            mispred        <= 1'b0;
            update_pc      <= '0;
            update_opcode  <= '0;
            update_valid   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            branch_count   <= '0;
            mispred_count  <= '0;
            protocol_err   <= 1'b0;
        end else begin
            update_valid   <= 1'b0;
            mispred        <= 1'b0;
            redirect_valid <= 1'b0;

            case (state)
                RUN: begin
                    count     <= count_nxt;
                    fifo_full <= (count_nxt == CNT_W'(INFLIGHT_DEPTH));
                    if (mis) begin
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        state  <= FLUSH;
                    end else begin
                        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                    end

                    if (resolve) begin
                        update_valid  <= 1'b1;
                        actual_pred   <= ex_taken;
                        update_pc     <= ex_pc;
                        update_opcode <= ex_opcode;
                        mispred       <= mis;
                        branch_count  <= branch_count + DATA_WIDTH'(1);
                    end

                    if (mis) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= ex_taken ? ex_target : pc_plus4;
                        mispred_count  <= mispred_count + DATA_WIDTH'(1);
                    end

                    if (err_set) protocol_err <= 1'b1;
                end
                // Wrong-path fetch and execute traffic is still arriving; ignore it for one cycle.
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
